alu_scheduler: RTL and testbench

ALU_SCHEDULER -- requirements
Module: alu_scheduler

---
 rtl/alu_scheduler.sv | 125 ++++++++++++
 tb/tb_alu_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_scheduler.sv
// Round-robin front end for a single shared, combinational ALU. Operations are
// issued one at a time and broadcast on a result bus (CDB) with a destination tag.
module alu_scheduler #(
  parameter int NREQ    = 4,
  parameter int TAG_W   = 4,
  parameter int MUL_LAT = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [3*NREQ-1:0]       req_op,
  input  logic [32*NREQ-1:0]      req_src1,
  input  logic [32*NREQ-1:0]      req_src2,
  input  logic [TAG_W*NREQ-1:0]   req_tag,
  output logic [2:0]              alu_op,
  output logic [31:0]             alu_src1,
  output logic [31:0]             alu_src2,
  input  logic [31:0]             alu_result,
  output logic                    cdb_valid,
  input  logic                    cdb_ready,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [31:0]             cdb_data,
  output logic                    busy
);

  localparam int         PTR_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [2:0] OP_MUL  = 3'd1;
  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  state_e             state, state_nxt;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic               handshake;
  logic [3:0]         cnt;
  logic [2:0]         op_q;
  logic [31:0]        src1_q, src2_q;
  logic [TAG_W-1:0]   tag_q;
  logic [2:0]         gnt_op;

  // Rotating priority search: first valid requester at or above rr_ptr, modulo NREQ.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned; that is what keeps a latch from being inferred.
    int idx;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_any && req_valid[PTR_W'(idx)]) begin
        gnt_any = 1'b1;
        gnt_idx = PTR_W'(idx);
      end
    end
  end

  assign handshake = (state == IDLE) && !rst && gnt_any;
  assign gnt_op    = req_op[3*gnt_idx +: 3];

  // NOTE: reset is sampled on the clock edge only, so it sits inside the
  // clocked block rather than in its sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (handshake)    state_nxt = EXEC;
      EXEC:    if (cnt == 4'd0)  state_nxt = DONE;
      DONE:    if (cdb_ready)    state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (handshake) req_ready[gnt_idx] = 1'b1;
    busy      = (state != IDLE);
    cdb_valid = (state == DONE);
  end

  // Operands are captured at the grant so the ALU never sees the request ports.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      cnt      <= '0;
      op_q     <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      tag_q    <= '0;
      cdb_data <= '0;
      cdb_tag  <= '0;
    end else begin
      if (handshake) begin
        op_q   <= gnt_op;
        src1_q <= req_src1[32*gnt_idx +: 32];
        src2_q <= req_src2[32*gnt_idx +: 32];
        tag_q  <= req_tag[TAG_W*gnt_idx +: TAG_W];
        cnt    <= (gnt_op == OP_MUL) ? MUL_CNT : 4'd0;
        rr_ptr <= (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end else if (state == EXEC && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      // Codes 4-7 are illegal and broadcast zero instead of whatever the ALU returns.
      if (state == EXEC && cnt == 4'd0) begin
        cdb_data <= op_q[2] ? 32'd0 : alu_result;
        cdb_tag  <= tag_q;
      end
    end
  end

  assign alu_op   = op_q;
  assign alu_src1 = src1_q;
  assign alu_src2 = src2_q;

endmodule

// File: tb/tb_alu_scheduler.sv
// Bench for alu_scheduler: directed scenarios plus randomized traffic, all checked
// by a transaction-level model of grants, latencies and broadcasts.
module tb_alu_scheduler;

  localparam int NREQ    = 4;
  localparam int TAG_W   = 4;
  localparam int MUL_LAT = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [3*NREQ-1:0]     req_op;
  logic [32*NREQ-1:0]    req_src1, req_src2;
  logic [TAG_W*NREQ-1:0] req_tag;
  logic [2:0]            alu_op;
  logic [31:0]           alu_src1, alu_src2, alu_result;
  logic                  cdb_valid, cdb_ready;
  logic [TAG_W-1:0]      cdb_tag;
  logic [31:0]           cdb_data;
  logic                  busy;

  always #5 clk = ~clk;

  alu_scheduler #(.NREQ(NREQ), .TAG_W(TAG_W), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_src1(req_src1), .req_src2(req_src2), .req_tag(req_tag),
    .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_result(alu_result),
    .cdb_valid(cdb_valid), .cdb_ready(cdb_ready), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .busy(busy)
  );

  // Shared ALU; illegal codes return junk so the scheduler's zeroing is visible.
  function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a * b;
      3'd2:    return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    return a << b[4:0];
      default: return 32'hdead_beef;
    endcase
  endfunction

  function automatic logic [31:0] exp_fn(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    return (op > 3'd3) ? 32'd0 : alu_fn(op, a, b);
  endfunction

  always_comb alu_result = alu_fn(alu_op, alu_src1, alu_src2);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Transaction model: who is granted, when the result must appear, what it holds.
  bit               model_on = 1'b0;
  bit               m_busy   = 1'b0;
  int               m_ptr    = 0;
  int               m_due    = 0;
  int               m_cyc    = 0;
  int               m_pick;
  int               m_i;
  logic [2:0]       m_op;
  logic [31:0]      m_data;
  logic [TAG_W-1:0] m_tag;
  logic [NREQ-1:0]  m_rdy;

  always @(negedge clk) begin
    if (model_on) begin
      m_cyc++;
      if (rst) begin
        check("ready_in_rst", 32'(req_ready), 32'd0);
        m_busy = 1'b0;
        m_ptr  = 0;
      end else if (!m_busy) begin
        m_pick = -1;
        for (int k = 0; k < NREQ; k++) begin
          m_i = (m_ptr + k) % NREQ;
          if (m_pick < 0 && req_valid[m_i]) m_pick = m_i;
        end
        m_rdy = '0;
        if (m_pick >= 0) m_rdy[m_pick] = 1'b1;
        check("grant", 32'(req_ready), 32'(m_rdy));
        check("busy_idle", 32'(busy), 32'd0);
        check("valid_idle", 32'(cdb_valid), 32'd0);
        if (m_pick >= 0) begin
          m_op   = req_op[3*m_pick +: 3];
          m_data = exp_fn(m_op, req_src1[32*m_pick +: 32], req_src2[32*m_pick +: 32]);
          m_tag  = req_tag[TAG_W*m_pick +: TAG_W];
          m_due  = m_cyc + 1 + ((m_op == 3'd1) ? MUL_LAT : 1);
          m_busy = 1'b1;
          m_ptr  = (m_pick + 1) % NREQ;
        end
      end else begin
        check("ready_busy", 32'(req_ready), 32'd0);
        check("busy_flag", 32'(busy), 32'd1);
        if (m_cyc < m_due) begin
          check("valid_early", 32'(cdb_valid), 32'd0);
        end else begin
          check("valid_due", 32'(cdb_valid), 32'd1);
          check("cdb_data", cdb_data, m_data);
          check("cdb_tag", 32'(cdb_tag), 32'(m_tag));
          if (cdb_ready) m_busy = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic set_req(input int idx, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [TAG_W-1:0] tg);
    req_op[3*idx +: 3]         = op;
    req_src1[32*idx +: 32]     = a;
    req_src2[32*idx +: 32]     = b;
    req_tag[TAG_W*idx +: TAG_W] = tg;
  endtask

  // Waits (bounded) for requester idx to be granted; returns idle cycles waited.
  task automatic wait_grant(input int idx, output int waited);
    bit seen;
    seen   = 1'b0;
    waited = 0;
    while (!seen && waited < 20) begin
      @(negedge clk);
      seen = req_ready[idx];
      if (!seen) waited++;
    end
  endtask

  task automatic run_op(input string nm, input int idx, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tg, input logic [31:0] exp_d,
                        input int exp_lat);
    int  w, n, nb;
    bit  seen;
    set_req(idx, op, a, b, tg);
    req_valid      = '0;
    req_valid[idx] = 1'b1;
    cdb_ready      = 1'b1;
    wait_grant(idx, w);
    check({nm, "_grant_wait"}, 32'(w), 32'd0);
    step();
    req_valid = '0;
    n    = 0;
    nb   = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (busy) nb++;
      seen = cdb_valid;
    end
    check({nm, "_latency"}, 32'(n), 32'(exp_lat + 1));
    check({nm, "_data"}, cdb_data, exp_d);
    check({nm, "_tag"}, 32'(cdb_tag), 32'(tg));
    check({nm, "_busy_cycles"}, 32'(nb), 32'(exp_lat + 1));
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    int w, g, h;
    int g_idx[5];
    int g_cyc[5];
    int cyc;

    rst = 1'b1; req_valid = '0; req_op = '0; req_src1 = '0; req_src2 = '0;
    req_tag = '0; cdb_ready = 1'b0;
    step();
    model_on = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_cdb_valid", 32'(cdb_valid), 32'd0);
    check("rst_cdb_data", cdb_data, 32'd0);
    check("rst_cdb_tag", 32'(cdb_tag), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_alu_src1", alu_src1, 32'd0);
    step();

    run_op("add", 0, 3'd0, 32'd5, 32'd7, 4'd3, 32'd12, 1);
    run_op("mul", 1, 3'd1, 32'd6, 32'd7, 4'd6, 32'd42, MUL_LAT);
    run_op("illegal", 2, 3'd5, 32'd8, 32'd9, 4'd9, 32'd0, 1);
    run_op("bge_lt", 3, 3'd2, 32'd3, 32'd9, 4'd1, 32'd0, 1);
    run_op("bge_ge", 0, 3'd2, 32'd9, 32'd3, 4'd2, 32'd1, 1);

    // All requesters held valid: rotation order and spacing between grants.
    pulse_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 3'd0, 32'(i * 10), 32'd1, 4'(i));
    req_valid = '1;
    cdb_ready = 1'b1;
    g   = 0;
    cyc = 0;
    while (g < 5 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (req_ready != '0) begin
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) g_idx[g] = i;
        g_cyc[g] = cyc;
        g++;
      end
    end
    check("rr_grant_count", 32'(g), 32'd5);
    for (int i = 0; i < 5; i++) begin
      check("rr_order", 32'(g_idx[i]), 32'(i % NREQ));
      if (i > 0) check("rr_spacing", 32'(g_cyc[i] - g_cyc[i-1]), 32'd3);
    end
    step();
    req_valid = '0;
    repeat (4) step();

    // Consumer stalls: result held, no grants while other requesters wait.
    set_req(3, 3'd3, 32'd1, 32'd4, 4'd5);
    req_valid = 4'b1000;
    wait_grant(3, w);
    check("sll_grant_wait", 32'(w), 32'd0);
    step();
    req_valid = 4'b0111;
    cdb_ready = 1'b0;
    h = 0;
    while (!cdb_valid && h < 20) begin
      @(negedge clk);
      h++;
    end
    check("sll_valid", 32'(cdb_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("sll_hold_data", cdb_data, 32'd16);
      check("sll_hold_valid", 32'(cdb_valid), 32'd1);
      check("sll_hold_ready", 32'(req_ready), 32'd0);
    end
    step();
    req_valid = '0;
    cdb_ready = 1'b1;
    @(negedge clk);
    check("sll_last_data", cdb_data, 32'd16);
    repeat (3) step();
    check("sll_drained", 32'(busy), 32'd0);

    // Reset in the second EXEC cycle of a multiply discards it.
    pulse_reset();
    set_req(2, 3'd1, 32'd11, 32'd13, 4'd7);
    req_valid = 4'b0100;
    wait_grant(2, w);
    check("abort_grant_wait", 32'(w), 32'd0);
    step();
    req_valid = '0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    h = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (cdb_valid) h++;
    end
    check("abort_no_broadcast", 32'(h), 32'd0);
    step();
    req_valid = 4'b0110;
    @(negedge clk);
    check("abort_next_grant", 32'(req_ready), 32'b0010);
    step();
    req_valid = '0;
    repeat (6) step();

    // Randomized traffic with occasional resets and consumer stalls.
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      req_valid = NREQ'($urandom);
      cdb_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        set_req(i, 3'($urandom_range(0, 7)),
                ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)),
                ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)),
                TAG_W'($urandom));
      end
      step();
    end
    rst = 1'b0;
    req_valid = '0;
    cdb_ready = 1'b1;
    repeat (MUL_LAT + 4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
